// File: rtl/game_round_sequencer.sv
// game_round_sequencer: round/level/lives sequencer for a simple arcade game.
// A rising edge on launch_key starts play; the game master reports each round
// with a round_end pulse and a round_won flag. Won rounds bump a BCD score and
// advance the level every WINS_PER_LEVEL wins. Lost rounds cost a life. After
// each round the sequencer waits for the end-of-round display timer to run and
// finish before resuming play or declaring game over.
//
// Ports:
//   clk                        system clock, rising edge
//   rst                        asynchronous active-high reset
//   launch_key                 player key (level); only its rising edge acts
//   round_end                  one-cycle end-of-round pulse from the game master
//   round_won                  round result, valid with round_end
//   end_of_game_timer_running  end-of-round display timer busy
//   master_enable              lets the game master leave its start state
//   target_speed               sprite speed magnitude, level + 1
//   level                      current level
//   lives                      remaining lives
//   score_bcd                  won-round count, two BCD digits ([7:4] tens)
//   score_update               one-cycle pulse after a scored round
//   game_over                  high while no lives remain
module game_round_sequencer #(
  parameter int unsigned INIT_LIVES     = 3,
  parameter int unsigned WINS_PER_LEVEL = 4,
  parameter int unsigned MAX_LEVEL      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       launch_key,
  input  logic       round_end,
  input  logic       round_won,
  input  logic       end_of_game_timer_running,
  output logic       master_enable,
  output logic [3:0] target_speed,
  output logic [2:0] level,
  output logic [1:0] lives,
  output logic [7:0] score_bcd,
  output logic       score_update,
  output logic       game_over
);

  localparam logic [1:0] InitLives    = 2'(INIT_LIVES);
  localparam logic [3:0] WinsPerLevel = 4'(WINS_PER_LEVEL);
  localparam logic [2:0] MaxLevel     = 3'(MAX_LEVEL);

  typedef enum logic [1:0] {StIdle, StPlay, StResult, StOver} state_e;

  state_e      state_q, state_d;
  logic        key_prev_q;
  logic        launch_edge;
  logic        seen_running_q, seen_running_d;
  logic [3:0]  win_cnt_q, win_cnt_d;
  logic [2:0]  level_q, level_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic        score_update_q, score_update_d;
  logic        master_enable_q, master_enable_d;
  logic        game_over_q, game_over_d;
  logic [3:0]  target_speed_q, target_speed_d;
  logic [7:0]  score_inc;
  logic [3:0]  win_inc;

  assign launch_edge = launch_key & ~key_prev_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (launch_edge) state_d = StPlay;
      StPlay:   if (round_end) state_d = StResult;
      // Leave only after the timer has been seen busy and has since gone idle.
      StResult: if (seen_running_q && !end_of_game_timer_running) begin
        state_d = (lives_q == 2'd0) ? StOver : StPlay;
      end
      StOver:   if (launch_edge) state_d = StPlay;
      default:  state_d = StIdle;
    endcase
  end

  // Saturating two-digit BCD increment of the score.
  always_comb begin
    score_inc = score_q;
    if (score_q != 8'h99) begin
      if (score_q[3:0] == 4'd9) begin
        score_inc = {score_q[7:4] + 4'd1, 4'd0};
      end else begin
        score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
      end
    end
  end

  assign win_inc = win_cnt_q + 4'd1;

  // Output and datapath next-state logic.
  always_comb begin
    seen_running_d = seen_running_q;
    win_cnt_d      = win_cnt_q;
    level_d        = level_q;
    lives_d        = lives_q;
    score_d        = score_q;
    score_update_d = 1'b0;
    // master_enable follows the state one cycle late; game_over tracks the
    // next state so it clears in the same cycle the counters are reloaded.
    master_enable_d = (state_q == StPlay);
    game_over_d     = (state_d == StOver);
    unique case (state_q)
      StPlay: begin
        if (round_end) begin
          seen_running_d = 1'b0;
          if (round_won) begin
            score_d        = score_inc;
            score_update_d = 1'b1;
            if (win_inc == WinsPerLevel) begin
              win_cnt_d = 4'd0;
              if (level_q < MaxLevel) level_d = level_q + 3'd1;
            end else begin
              win_cnt_d = win_inc;
            end
          end else if (lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
        end
      end
      StResult: begin
        if (end_of_game_timer_running) seen_running_d = 1'b1;
      end
      StOver: begin
        if (launch_edge) begin
          score_d   = 8'h00;
          lives_d   = InitLives;
          level_d   = 3'd0;
          win_cnt_d = 4'd0;
        end
      end
      default: ;
    endcase
    target_speed_d = {1'b0, level_d} + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_prev_q      <= 1'b0;
      seen_running_q  <= 1'b0;
      win_cnt_q       <= 4'd0;
      level_q         <= 3'd0;
      lives_q         <= InitLives;
      score_q         <= 8'h00;
      score_update_q  <= 1'b0;
      master_enable_q <= 1'b0;
      game_over_q     <= 1'b0;
      target_speed_q  <= 4'd1;
    end else begin
      key_prev_q      <= launch_key;
      seen_running_q  <= seen_running_d;
      win_cnt_q       <= win_cnt_d;
      level_q         <= level_d;
      lives_q         <= lives_d;
      score_q         <= score_d;
      score_update_q  <= score_update_d;
      master_enable_q <= master_enable_d;
      game_over_q     <= game_over_d;
      target_speed_q  <= target_speed_d;
    end
  end

  assign master_enable = master_enable_q;
  assign target_speed  = target_speed_q;
  assign level         = level_q;
  assign lives         = lives_q;
  assign score_bcd     = score_q;
  assign score_update  = score_update_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed self-checking bench for game_round_sequencer (default parameters).
module tb_game_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       launch_key;
  logic       round_end;
  logic       round_won;
  logic       end_of_game_timer_running;
  logic       master_enable;
  logic [3:0] target_speed;
  logic [2:0] level;
  logic [1:0] lives;
  logic [7:0] score_bcd;
  logic       score_update;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  game_round_sequencer #(
    .INIT_LIVES    (3),
    .WINS_PER_LEVEL(4),
    .MAX_LEVEL     (7)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .launch_key               (launch_key),
    .round_end                (round_end),
    .round_won                (round_won),
    .end_of_game_timer_running(end_of_game_timer_running),
    .master_enable            (master_enable),
    .target_speed             (target_speed),
    .level                    (level),
    .lives                    (lives),
    .score_bcd                (score_bcd),
    .score_update             (score_update),
    .game_over                (game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full round: end pulse, timer busy one cycle, timer idle; returns with
  // master_enable settled (state back in PLAY, or OVER after the last life).
  task automatic play_round(input logic won);
    round_end = 1'b1;
    round_won = won;
    tick();
    round_end = 1'b0;
    round_won = 1'b0;
    check("score_update_pulse", score_update, won);
    end_of_game_timer_running = 1'b1;
    tick();
    end_of_game_timer_running = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    launch_key = 1'b0;
    round_end = 1'b0;
    round_won = 1'b0;
    end_of_game_timer_running = 1'b0;
    repeat (3) tick();
    check("rst_master_enable", master_enable, 1'b0);
    check("rst_lives", lives, 2'd3);
    check("rst_level", level, 3'd0);
    check("rst_target_speed", target_speed, 4'd1);
    check("rst_score", score_bcd, 8'h00);
    check("rst_game_over", game_over, 1'b0);
    rst = 1'b0;
    tick();

    // round_end in IDLE is ignored
    round_end = 1'b1;
    round_won = 1'b1;
    tick();
    round_end = 1'b0;
    round_won = 1'b0;
    tick();
    check("idle_round_end_score", score_bcd, 8'h00);
    check("idle_round_end_upd", score_update, 1'b0);
    check("idle_master_enable", master_enable, 1'b0);

    // launch: master_enable rises two edges after the key edge
    launch_key = 1'b1;
    tick();
    check("launch_enable_early", master_enable, 1'b0);
    tick();
    check("launch_enable", master_enable, 1'b1);
    check("launch_lives", lives, 2'd3);
    check("launch_speed", target_speed, 4'd1);

    // four wins -> level 1
    for (int i = 0; i < 4; i++) play_round(1'b1);
    check("four_wins_score", score_bcd, 8'h04);
    check("four_wins_level", level, 3'd1);
    check("four_wins_speed", target_speed, 4'd2);
    check("four_wins_enable", master_enable, 1'b1);

    // 09 -> 10
    for (int i = 0; i < 5; i++) play_round(1'b1);
    check("score_09", score_bcd, 8'h09);
    play_round(1'b1);
    check("score_10", score_bcd, 8'h10);
    check("level_after_10", level, 3'd2);

    // up to 99, then saturate
    for (int i = 0; i < 89; i++) play_round(1'b1);
    check("score_99", score_bcd, 8'h99);
    check("level_sat", level, 3'd7);
    check("speed_sat", target_speed, 4'd8);
    play_round(1'b1);
    check("score_99_sat", score_bcd, 8'h99);
    check("level_sat2", level, 3'd7);

    // three losses with launch_key still held high
    play_round(1'b0);
    check("lives_2", lives, 2'd2);
    play_round(1'b0);
    check("lives_1", lives, 2'd1);
    check("not_over_yet", game_over, 1'b0);
    play_round(1'b0);
    check("lives_0", lives, 2'd0);
    check("over_game_over", game_over, 1'b1);
    check("over_enable", master_enable, 1'b0);
    check("loss_keeps_score", score_bcd, 8'h99);

    // OVER: round_end ignored, held key does not restart
    round_end = 1'b1;
    round_won = 1'b1;
    tick();
    round_end = 1'b0;
    round_won = 1'b0;
    repeat (3) tick();
    check("over_ignore_score", score_bcd, 8'h99);
    check("over_ignore_lives", lives, 2'd0);
    check("over_held_key", game_over, 1'b1);
    check("over_held_enable", master_enable, 1'b0);

    // fresh edge restarts with everything reloaded in the same cycle
    launch_key = 1'b0;
    tick();
    launch_key = 1'b1;
    tick();
    check("restart_lives", lives, 2'd3);
    check("restart_score", score_bcd, 8'h00);
    check("restart_level", level, 3'd0);
    check("restart_speed", target_speed, 4'd1);
    check("restart_game_over", game_over, 1'b0);
    tick();
    check("restart_enable", master_enable, 1'b1);

    // RESULT waits for the timer to be seen busy then idle
    round_end = 1'b1;
    round_won = 1'b0;
    tick();
    round_end = 1'b0;
    check("result_lives", lives, 2'd2);
    repeat (9) tick();
    check("result_wait_enable", master_enable, 1'b0);
    // round_end while in RESULT is ignored
    round_end = 1'b1;
    round_won = 1'b1;
    tick();
    round_end = 1'b0;
    round_won = 1'b0;
    tick();
    check("result_ignore_score", score_bcd, 8'h00);
    check("result_ignore_upd", score_update, 1'b0);
    end_of_game_timer_running = 1'b1;
    repeat (3) tick();
    check("result_busy_enable", master_enable, 1'b0);
    end_of_game_timer_running = 1'b0;
    tick();
    check("result_exit_pending", master_enable, 1'b0);
    tick();
    check("result_exit_enable", master_enable, 1'b1);

    // launch edge in PLAY is ignored
    launch_key = 1'b0;
    tick();
    launch_key = 1'b1;
    repeat (2) tick();
    check("play_edge_lives", lives, 2'd2);
    check("play_edge_enable", master_enable, 1'b1);

    // reset mid-round discards progress asynchronously
    play_round(1'b1);
    check("pre_reset_score", score_bcd, 8'h01);
    rst = 1'b1;
    #1;
    check("async_rst_score", score_bcd, 8'h00);
    check("async_rst_enable", master_enable, 1'b0);
    check("async_rst_lives", lives, 2'd3);
    launch_key = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_enable", master_enable, 1'b0);
    check("post_rst_score", score_bcd, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_round_sequencer.md
GAME_ROUND_SEQUENCER -- requirements
Module: game_round_sequencer

Interface
Parameters:
REQ-001 SHALL have parameter INIT_LIVES, default 3, lives loaded at game start (1..3).
REQ-002 SHALL have parameter WINS_PER_LEVEL, default 4, won rounds needed to advance one level (1..15).
REQ-003 SHALL have parameter MAX_LEVEL, default 7, level saturation value (0..7).
Ports:
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port launch_key  input  1  player key, level; only its rising edge is used.
REQ-007 SHALL have port round_end  input  1  one-cycle pulse from the game master marking the end of a round.
REQ-008 SHALL have port round_won  input  1  round result, sampled only in the cycle round_end=1.
REQ-009 SHALL have port end_of_game_timer_running  input  1  end-of-round display timer busy.
REQ-010 SHALL have port master_enable  output  1  permits the game master to leave its start state.
REQ-011 SHALL have port target_speed  output  4  target speed magnitude for the sprite datapath.
REQ-012 SHALL have port level  output  3  current level.
REQ-013 SHALL have port lives  output  2  remaining lives.
REQ-014 SHALL have port score_bcd  output  8  won-round count as two BCD digits, [7:4] tens.
REQ-015 SHALL have port score_update  output  1  one-cycle pulse when score changes.
REQ-016 SHALL have port game_over  output  1  high while no lives remain.

Function
REQ-017 SHALL register launch_key into key_prev; launch_edge = launch_key & ~key_prev.
REQ-018 SHALL implement states IDLE, PLAY, RESULT, OVER; all outputs registered, valid the cycle after the state transition.
REQ-019 IDLE: master_enable=0; launch_edge -> PLAY.
REQ-020 PLAY: master_enable=1; round_end -> RESULT; no other exit.
REQ-021 On round_end in PLAY with round_won=1: score_bcd +1 in BCD (09->10, 99 saturates, still pulses score_update); win_cnt +1; when win_cnt reaches WINS_PER_LEVEL it clears to 0 and level increments, saturating at MAX_LEVEL.
REQ-022 On round_end in PLAY with round_won=0: lives decrements by 1; score, level, win_cnt unchanged; score_update stays 0.
REQ-023 score_update SHALL be 1 exactly in the cycle after an accepted won round_end, otherwise 0.
REQ-024 RESULT: master_enable=0; set seen_running when end_of_game_timer_running=1; exit only when seen_running=1 and end_of_game_timer_running=0; exit to OVER if lives=0 else PLAY; seen_running clears on entry.
REQ-025 OVER: game_over=1, master_enable=0; launch_edge -> PLAY with score_bcd=0, lives=INIT_LIVES, level=0, win_cnt=0, game_over=0 all in the same cycle.
REQ-026 round_end in IDLE, RESULT or OVER SHALL be ignored (no counter change).
REQ-027 target_speed SHALL equal level+1 (range 1..8), updating the cycle level changes.
REQ-028 launch_edge in PLAY or RESULT SHALL be ignored; a key held through a transition creates no new edge.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, key_prev=0, master_enable=0, score_bcd=8'h00, score_update=0, lives=INIT_LIVES, level=0, win_cnt=0, seen_running=0, game_over=0, target_speed=1.
REQ-030 Reset asserted mid-round SHALL discard round progress; after release no output changes until launch_edge.

Verification
REQ-031 Reset, launch_key 0->1 -> master_enable=1 two cycles after the edge; lives=3, level=0, target_speed=1.
REQ-032 Four won rounds (round_end+round_won, timer pulse 1 then 0 each) -> score_bcd=8'h04, level=1, target_speed=2, four score_update pulses.
REQ-033 Score 8'h09 plus one won round -> 8'h10; score 8'h99 plus one won round -> stays 8'h99, score_update still pulses.
REQ-034 Three lost rounds from start -> lives 2,1,0; after third timer completes, game_over=1, master_enable=0; launch_edge -> lives=3, score=0, game_over=0, PLAY.
REQ-035 In RESULT, end_of_game_timer_running held 0 for 10 cycles -> remains RESULT; then 1 for 3 cycles, 0 -> leaves RESULT next edge.
REQ-036 round_end pulses in IDLE and OVER, launch_key held high across OVER entry -> no counter change, no restart without a fresh rising edge.
